// File: rtl/adc_pmod_pkg.sv
// adc_pmod_pkg: shared types, constants and sample formatting for the PMOD-AD1 capture path.
// Build option: define ADC_PMOD_TWOS_COMP_EN to emit left-justified two's-complement words
// instead of zero-extended offset-binary codes.
package adc_pmod_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      PUSH  = 2'd2,
      QUIET = 2'd3
   } state_t;

   localparam int unsigned FRAME_BITS      = 16;
   localparam int unsigned DATA_BITS       = 12;
   localparam int unsigned BYTES_PER_FRAME = 4;

   // 12-bit ADC code to the 16-bit FIFO word
   function automatic logic [15:0] format_word(input logic [DATA_BITS-1:0] d);
`ifdef ADC_PMOD_TWOS_COMP_EN
      // offset binary -> signed, left-justified to match the DAC path
      return {~d[11], d[10:0], 4'b0000};
`else
      return {4'b0000, d};
`endif
   endfunction

endpackage

// File: rtl/adc_pmod_sclk_gen.sv
// adc_pmod_sclk_gen: SCLK generator for one 16-bit conversion frame.
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   start           one-cycle request to begin a frame (SCLK goes low on the next edge)
//   sclk            serial clock, idles high
//   capture_c       high in the cycle whose closing edge drives SCLK 0->1
//   done_c          high in the last cycle of the 16th SCLK period
import adc_pmod_pkg::*;

module adc_pmod_sclk_gen #(
   parameter int unsigned SCLK_HALF = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic sclk,
   output logic capture_c,
   output logic done_c
);

   localparam int unsigned HW = $clog2(SCLK_HALF + 1);
   localparam int unsigned BW = $clog2(FRAME_BITS);

   logic          active;
   logic          high_phase;
   logic [HW-1:0] half_cnt;
   logic [BW-1:0] bit_cnt;
   logic          half_end;

   assign half_end  = (half_cnt == HW'(SCLK_HALF - 1));
   assign capture_c = active && half_end && !high_phase;
   assign done_c    = active && half_end && high_phase && (bit_cnt == BW'(FRAME_BITS - 1));

   // half-period divider and bit counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         active     <= 1'b0;
         high_phase <= 1'b0;
         half_cnt   <= '0;
         bit_cnt    <= '0;
         sclk       <= 1'b1;
      end else if (start) begin
         active     <= 1'b1;
         high_phase <= 1'b0;
         half_cnt   <= '0;
         bit_cnt    <= '0;
         sclk       <= 1'b0;
      end else if (active) begin
         if (half_end) begin
            half_cnt <= '0;
            if (!high_phase) begin
               high_phase <= 1'b1;
               sclk       <= 1'b1;
            end else begin
               high_phase <= 1'b0;
               bit_cnt    <= bit_cnt + BW'(1);
               // after the last period SCLK stays at its idle-high level
               if (bit_cnt == BW'(FRAME_BITS - 1)) begin
                  active <= 1'b0;
                  sclk   <= 1'b1;
               end else begin
                  sclk <= 1'b0;
               end
            end
         end else begin
            half_cnt <= half_cnt + HW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_pmod.sv
// adc_pmod: PMOD-AD1 (dual AD7476A) capture path feeding the tracking FIFO write side.
// Each sample tick runs one 16-SCLK frame, captures both channels, and writes
// A[7:0], A[15:8], B[7:0], B[15:8] into the FIFO.
// Build option: ADC_PMOD_TWOS_COMP_EN selects two's-complement word formatting.
// Ports:
//   clk, reset           system clock, synchronous active-low reset
//   enable               run the sample-rate counter
//   sample_period        clk cycles per sample (values < 2 act as 2)
//   pmod_cs, pmod_sclk   ADC chip select (active low) and serial clock (idle high)
//   pmod_din             [0] ADC A (left), [1] ADC B (right)
//   fifo_clk, fifo_data, fifo_write, fifo_free   FIFO write side
//   status_clear         clears overflow and overrun
//   overflow             sticky: frame dropped for lack of FIFO space
//   overrun              sticky: sample tick arrived outside IDLE
//   frame_count          frames written, wrapping
import adc_pmod_pkg::*;

module adc_pmod #(
   parameter int unsigned SCLK_HALF    = 2,
   parameter int unsigned QUIET_CYCLES = 4,
   parameter int unsigned FREE_W       = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [15:0]       sample_period,
   output logic              pmod_cs,
   output logic              pmod_sclk,
   input  logic [1:0]        pmod_din,
   output logic              fifo_clk,
   output logic [7:0]        fifo_data,
   output logic              fifo_write,
   input  logic [FREE_W-1:0] fifo_free,
   input  logic              status_clear,
   output logic              overflow,
   output logic              overrun,
   output logic [15:0]       frame_count
);

   localparam int unsigned QW  = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
   localparam int unsigned BIW = $clog2(BYTES_PER_FRAME);

   state_t               state;
   logic [15:0]          period_cnt;
   logic [15:0]          period;
   logic                 tick_c;
   logic                 start_c;
   logic                 capture_c;
   logic                 done_c;
   logic [DATA_BITS-1:0] shift_a;
   logic [DATA_BITS-1:0] shift_b;
   logic [BIW-1:0]       byte_idx;
   logic [QW-1:0]        quiet_cnt;
   logic [15:0]          word_a;
   logic [15:0]          word_b;
   logic [7:0]           byte_sel;

   assign fifo_clk = clk;

   // effective period and sample tick; >= guards against a period shrinking under the counter
   assign period  = (sample_period < 16'd2) ? 16'd2 : sample_period;
   assign tick_c  = enable && (period_cnt >= period - 16'd1);
   assign start_c = (state == IDLE) && tick_c;

   always_ff @(posedge clk) begin
      if (!reset) begin
         period_cnt <= '0;
      end else if (!enable || tick_c) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + 16'd1;
      end
   end

   adc_pmod_sclk_gen #(
      .SCLK_HALF (SCLK_HALF)
   ) u_sclk_gen (
      .clk       (clk),
      .reset     (reset),
      .start     (start_c),
      .sclk      (pmod_sclk),
      .capture_c (capture_c),
      .done_c    (done_c)
   );

   // byte select for the FIFO stream
   always_comb begin
      word_a = format_word(shift_a);
      word_b = format_word(shift_b);
      case (byte_idx)
         BIW'(0): byte_sel = word_a[7:0];
         BIW'(1): byte_sel = word_a[15:8];
         BIW'(2): byte_sel = word_b[7:0];
         default: byte_sel = word_b[15:8];
      endcase
   end

   // frame sequencer, FIFO writer and status flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         pmod_cs     <= 1'b1;
         fifo_write  <= 1'b0;
         fifo_data   <= '0;
         overflow    <= 1'b0;
         overrun     <= 1'b0;
         frame_count <= '0;
         shift_a     <= '0;
         shift_b     <= '0;
         byte_idx    <= '0;
         quiet_cnt   <= '0;
      end else begin
         fifo_write <= 1'b0;
         case (state)
            IDLE: begin
               if (tick_c) begin
                  state   <= CONV;
                  pmod_cs <= 1'b0;
               end
            end
            CONV: begin
               // only the last 12 of 16 bits survive, dropping the leading zeros
               if (capture_c) begin
                  shift_a <= {shift_a[DATA_BITS-2:0], pmod_din[0]};
                  shift_b <= {shift_b[DATA_BITS-2:0], pmod_din[1]};
               end
               if (done_c) begin
                  pmod_cs  <= 1'b1;
                  state    <= PUSH;
                  byte_idx <= '0;
               end
            end
            PUSH: begin
               // space is checked once, so a frame is written whole or not at all
               if (byte_idx == '0 && fifo_free < FREE_W'(BYTES_PER_FRAME)) begin
                  overflow  <= 1'b1;
                  quiet_cnt <= '0;
                  state     <= (QUIET_CYCLES == 0) ? IDLE : QUIET;
               end else begin
                  fifo_write <= 1'b1;
                  fifo_data  <= byte_sel;
                  if (byte_idx == BIW'(BYTES_PER_FRAME - 1)) begin
                     byte_idx    <= '0;
                     frame_count <= frame_count + 16'd1;
                     quiet_cnt   <= '0;
                     state       <= (QUIET_CYCLES == 0) ? IDLE : QUIET;
                  end else begin
                     byte_idx <= byte_idx + BIW'(1);
                  end
               end
            end
            QUIET: begin
               if (quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                  quiet_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  quiet_cnt <= quiet_cnt + QW'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (tick_c && state != IDLE) begin
            overrun <= 1'b1;
         end
         // clear wins over a same-cycle set
         if (status_clear) begin
            overflow <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_adc_pmod.sv
// tb_adc_pmod: scoreboard bench for adc_pmod with a dual AD7476A behavioural model.
module tb_adc_pmod;

   localparam int unsigned FREE_W = 11;
`ifdef ADC_PMOD_TWOS_COMP_EN
   localparam logic [11:0] CODE_A = 12'h800;
   localparam logic [11:0] CODE_B = 12'hFFF;
   localparam logic [7:0]  EXP0 = 8'h00, EXP1 = 8'h00, EXP2 = 8'hF0, EXP3 = 8'h7F;
`else
   localparam logic [11:0] CODE_A = 12'hABC;
   localparam logic [11:0] CODE_B = 12'h123;
   localparam logic [7:0]  EXP0 = 8'hBC, EXP1 = 8'h0A, EXP2 = 8'h23, EXP3 = 8'h01;
`endif

   logic              clk;
   logic              reset;
   logic              enable;
   logic [15:0]       sample_period;
   logic              pmod_cs;
   logic              pmod_sclk;
   logic [1:0]        pmod_din;
   logic              fifo_clk;
   logic [7:0]        fifo_data;
   logic              fifo_write;
   logic [FREE_W-1:0] fifo_free;
   logic              status_clear;
   logic              overflow;
   logic              overrun;
   logic [15:0]       frame_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rc = 0;
   int run = 0;
   int low_len = 0;
   bit abort_pending = 1'b0;
   logic [7:0]  exp_q[$];
   logic [7:0]  e_byte;
   logic [15:0] word_a;
   logic [15:0] word_b;

   adc_pmod #(
      .SCLK_HALF    (2),
      .QUIET_CYCLES (4),
      .FREE_W       (FREE_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .sample_period (sample_period),
      .pmod_cs       (pmod_cs),
      .pmod_sclk     (pmod_sclk),
      .pmod_din      (pmod_din),
      .fifo_clk      (fifo_clk),
      .fifo_data     (fifo_data),
      .fifo_write    (fifo_write),
      .fifo_free     (fifo_free),
      .status_clear  (status_clear),
      .overflow      (overflow),
      .overrun       (overrun),
      .frame_count   (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ADC model: bit 15 after CS falls, next bit after each SCLK rise
   initial begin
      word_a = {4'h0, CODE_A};
      word_b = {4'h0, CODE_B};
   end
   always @(negedge pmod_cs) rc = 0;
   always @(posedge pmod_sclk) if (pmod_cs === 1'b0) rc = rc + 1;
   assign pmod_din = (rc < 16) ? {word_b[15 - rc], word_a[15 - rc]} : 2'b00;

   // completed frame: expect four bytes when space was available
   always @(posedge pmod_cs) begin
      if (reset === 1'b1) begin
         check("sclk_rises", 32'(rc), 32'd16);
         if (fifo_free >= FREE_W'(4)) begin
            exp_q.push_back(EXP0);
            exp_q.push_back(EXP1);
            exp_q.push_back(EXP2);
            exp_q.push_back(EXP3);
         end
      end
   end

   // monitor: FIFO bytes, burst length and CS low time
   always @(negedge clk) begin
      if (fifo_write === 1'b1) begin
         run++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got 0x%0h expected no write", fifo_data);
         end else begin
            e_byte = exp_q.pop_front();
            check("fifo_byte", 32'(fifo_data), 32'(e_byte));
         end
      end else if (run != 0) begin
         check("burst_len", 32'(run), 32'd4);
         run = 0;
      end
      if (pmod_cs === 1'b0) begin
         low_len++;
      end else if (low_len != 0) begin
         if (abort_pending) abort_pending = 1'b0;
         else check("cs_low_len", 32'(low_len), 32'd64);
         low_len = 0;
      end
   end

   task automatic wait_cs(input logic lvl, input int max_cyc, input string what);
      int n = 0;
      while (pmod_cs !== lvl && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (pmod_cs !== lvl) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, cs=%b expected %b", what, pmod_cs, lvl);
      end
   endtask

   task automatic frame(input string what);
      wait_cs(1'b0, 300, what);
      wait_cs(1'b1, 100, what);
   endtask

   initial begin
      int t_fall;
      int t_prev;
      int lows;
      int n;
      t_prev = 0;
      reset = 1'b0;
      enable = 1'b0;
      sample_period = 16'd100;
      fifo_free = FREE_W'(1024);
      status_clear = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cs", 32'(pmod_cs), 32'd1);
      check("rst_sclk", 32'(pmod_sclk), 32'd1);
      check("rst_write", 32'(fifo_write), 32'd0);
      check("rst_data", 32'(fifo_data), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      reset = 1'b1;
      enable = 1'b1;

      // steady frames at period 100
      for (int i = 0; i < 3; i++) begin
         wait_cs(1'b0, 300, "frame_start");
         t_fall = cyc;
         if (i > 0) check("sample_period", 32'(t_fall - t_prev), 32'd100);
         t_prev = t_fall;
         wait_cs(1'b1, 100, "frame_end");
         repeat (10) @(negedge clk);
         check("frame_count", 32'(frame_count), 32'(i + 1));
      end
      check("no_overrun", 32'(overrun), 32'd0);

      // FIFO too full: frame dropped
      fifo_free = FREE_W'(3);
      frame("overflow_frame");
      repeat (10) @(negedge clk);
      check("overflow_set", 32'(overflow), 32'd1);
      check("overflow_count", 32'(frame_count), 32'd3);
      fifo_free = FREE_W'(1024);
      status_clear = 1'b1;
      @(negedge clk);
      status_clear = 1'b0;
      check("overflow_clear", 32'(overflow), 32'd0);

      // period shorter than a frame
      sample_period = 16'd20;
      for (int i = 0; i < 3; i++) begin
         frame("short_frame");
         repeat (6) @(negedge clk);
         check("short_count", 32'(frame_count), 32'(4 + i));
      end
      check("overrun_set", 32'(overrun), 32'd1);

      // reset during conversion at bit 7
      wait_cs(1'b0, 300, "abort_start");
      n = 0;
      while (rc < 7 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_bit7", 32'(rc >= 7), 32'd1);
      abort_pending = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_cs", 32'(pmod_cs), 32'd1);
      check("abort_sclk", 32'(pmod_sclk), 32'd1);
      check("abort_overrun", 32'(overrun), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      check("abort_frame_count", 32'(frame_count), 32'd0);
      check("abort_queue", 32'(exp_q.size()), 32'd0);
      sample_period = 16'd100;
      @(negedge clk);
      reset = 1'b1;
      frame("after_reset");
      repeat (10) @(negedge clk);
      check("after_reset_count", 32'(frame_count), 32'd1);

      // enable dropped mid-frame
      wait_cs(1'b0, 300, "enable_start");
      repeat (20) @(negedge clk);
      enable = 1'b0;
      wait_cs(1'b1, 100, "enable_end");
      repeat (10) @(negedge clk);
      check("enable_off_count", 32'(frame_count), 32'd2);
      lows = 0;
      repeat (300) begin
         @(negedge clk);
         if (pmod_cs !== 1'b1) lows++;
      end
      check("enable_off_cs_idle", 32'(lows), 32'd0);
      check("final_overrun", 32'(overrun), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
